// File: rtl/imem_rr_arbiter.sv
// imem_rr_arbiter: round-robin arbiter that lets N_CPUS fetch units share one
// instruction memory. One fetch is in flight at a time: IDLE picks a winner,
// WAIT issues the read and waits MEM_LAT cycles, RESP returns the data.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cpuReq            per-CPU fetch request
//   cpuImAddr         per-CPU word address
//   cpuImData         shared fetch data (valid where cpuImDataVld is set)
//   cpuImDataVld      one-hot data valid / advance enable
//   memAddr, memRe    instruction memory address and read strobe
//   memData           memory read data, MEM_LAT cycles after memRe
//   busy              a fetch is in flight
//   cpuGrantCnt       per-CPU delivered-fetch counters, present only when
//                     IMEM_RR_ARBITER_PERF_CNT_EN is defined

module imem_rr_arbiter #(
  parameter int unsigned N_CPUS  = 3,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CPUS-1:0]       cpuReq,
  input  logic [N_CPUS-1:0][31:0] cpuImAddr,
  output logic [31:0]             cpuImData,
  output logic [N_CPUS-1:0]       cpuImDataVld,
  output logic [31:0]             memAddr,
  output logic                    memRe,
  input  logic [31:0]             memData,
  output logic                    busy
`ifdef IMEM_RR_ARBITER_PERF_CNT_EN
  ,
  output logic [N_CPUS-1:0][31:0] cpuGrantCnt
`endif
);

  localparam int unsigned IdxW = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [31:0]     addr_q, addr_d;
  logic            re_q, re_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] pick;
  logic            any_req;
  logic [31:0]     cand;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    pick    = last_q;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_CPUS; k++) begin
      cand = (32'(last_q) + k) % N_CPUS;
      if (!any_req && cpuReq[cand[IdxW-1:0]]) begin
        any_req = 1'b1;
        pick    = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    addr_d  = addr_q;
    re_d    = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d   = pick;
          addr_d  = cpuImAddr[pick];
          re_d    = 1'b1;
          cnt_d   = 3'(MEM_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        last_d  = win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      win_q   <= '0;
      last_q  <= IdxW'(N_CPUS - 1);
      addr_q  <= '0;
      re_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cpuImDataVld = '0;
    if (state_q == StResp) begin
      cpuImDataVld = N_CPUS'(1) << win_q;
    end
  end

  // Data is passed straight through; only the valid bit qualifies it.
  assign cpuImData = memData;
  assign memAddr   = addr_q;
  assign memRe     = re_q;
  assign busy      = (state_q != StIdle);

`ifdef IMEM_RR_ARBITER_PERF_CNT_EN
  logic [N_CPUS-1:0][31:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    for (int unsigned i = 0; i < N_CPUS; i++) begin
      gcnt_d[i] = gcnt_q[i] + 32'(cpuImDataVld[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign cpuGrantCnt = gcnt_q;
`endif

endmodule

// File: tb/tb_imem_rr_arbiter.sv
// Bench for imem_rr_arbiter (N_CPUS=3, MEM_LAT=1): directed scenarios followed
// by random traffic, all checked against a transaction-level model.
module tb_imem_rr_arbiter;

  localparam int N   = 3;
  localparam int LAT = 1;

  logic             clk;
  logic             rst;
  logic [N-1:0]     cpuReq;
  logic [N-1:0][31:0] cpuImAddr;
  logic [31:0]      cpuImData;
  logic [N-1:0]     cpuImDataVld;
  logic [31:0]      memAddr;
  logic             memRe;
  logic [31:0]      memData;
  logic             busy;
`ifdef IMEM_RR_ARBITER_PERF_CNT_EN
  logic [N-1:0][31:0] cpuGrantCnt;
`endif

  imem_rr_arbiter #(
    .N_CPUS (N),
    .MEM_LAT(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpuReq      (cpuReq),
    .cpuImAddr   (cpuImAddr),
    .cpuImData   (cpuImData),
    .cpuImDataVld(cpuImDataVld),
    .memAddr     (memAddr),
    .memRe       (memRe),
    .memData     (memData),
    .busy        (busy)
`ifdef IMEM_RR_ARBITER_PERF_CNT_EN
    ,
    .cpuGrantCnt (cpuGrantCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction-level model: times are absolute cycle numbers.
  int          m_last;
  int          m_win;
  int          m_free_at;
  int          m_re_at;
  int          m_vld_at;
  logic [31:0] m_addr;
  int          m_cnt[N];

  // Memory model, driven from the DUT's read strobe.
  int          mem_due;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last    = N - 1;
    m_win     = 0;
    m_free_at = 0;
    m_re_at   = -1;
    m_vld_at  = -1;
    m_addr    = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    mem_due   = -1;
    mem_addr  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".memRe"}, 32'(memRe), 32'd0);
    check_eq({tag, ".memAddr"}, memAddr, 32'd0);
    check_eq({tag, ".vld"}, 32'(cpuImDataVld), 32'd0);
`ifdef IMEM_RR_ARBITER_PERF_CNT_EN
    for (int i = 0; i < N; i++) check_eq({tag, ".cnt"}, cpuGrantCnt[i], 32'd0);
`endif
  endtask

  // Entry and exit: 1 time unit after a rising edge.
  task automatic cycle(input logic [N-1:0] req, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] a2);
    logic [N-1:0] exp_vld;
    int           best;
    int           bd;
    int           d;
    cpuReq       = req;
    cpuImAddr[0] = a0;
    cpuImAddr[1] = a1;
    cpuImAddr[2] = a2;
    memData      = (cyc == mem_due) ? mem_f(mem_addr) : $urandom;
    @(negedge clk);
    exp_vld = (cyc == m_vld_at) ? N'(1 << m_win) : '0;
    check_eq("busy", 32'(busy), 32'(cyc < m_free_at));
    check_eq("memRe", 32'(memRe), 32'(cyc == m_re_at));
    check_eq("memAddr", memAddr, m_addr);
    check_eq("vld", 32'(cpuImDataVld), 32'(exp_vld));
    if (exp_vld != '0) begin
      check_eq("data", cpuImData, mem_f(m_addr));
      m_cnt[m_win]++;
    end
`ifdef IMEM_RR_ARBITER_PERF_CNT_EN
    for (int i = 0; i < N; i++) check_eq("grant_cnt", cpuGrantCnt[i], 32'(m_cnt[i]));
`endif
    if (memRe) begin
      mem_due  = cyc + LAT;
      mem_addr = memAddr;
    end
    // Arbitrate: nearest requester strictly after the last winner, cyclically.
    if (cyc >= m_free_at && req != '0) begin
      best = -1;
      bd   = N;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          d = (i - m_last - 1 + 2 * N) % N;
          if (d < bd) begin
            bd   = d;
            best = i;
          end
        end
      end
      m_win     = best;
      m_last    = best;
      m_addr    = cpuImAddr[best];
      m_re_at   = cyc + 1;
      m_vld_at  = cyc + 1 + LAT;
      m_free_at = cyc + 2 + LAT;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle of reset asserted mid-cycle, outputs checked while it is low.
  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst       = 1'b0;
    cpuReq    = '0;
    cpuImAddr = '0;
    memData   = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Solo request from CPU1.
    cycle(3'b010, 32'h0, 32'h10, 32'h0);
    idle(4);

    // Full contention.
    for (int i = 0; i < 12; i++) cycle(3'b111, 32'h100, 32'h200, 32'h300);
    idle(3);

    // Fairness: make CPU0 the last winner, then CPU0 and CPU2 compete.
    cycle(3'b001, 32'h40, 32'h0, 32'h0);
    idle(3);
    for (int i = 0; i < 6; i++) cycle(3'b101, 32'h44, 32'h0, 32'h48);
    idle(3);

    // Withdrawal: CPU1 drops its request and changes address after grant.
    cycle(3'b010, 32'h0, 32'h20, 32'h0);
    cycle(3'b000, 32'h0, 32'h99, 32'h0);
    idle(3);

    // Reset while in WAIT, then full contention must start at CPU0.
    for (int i = 0; i < 4; i++) cycle(3'b010, 32'h0, 32'h30, 32'h0);
    cycle(3'b110, 32'h0, 32'h31, 32'h32);
    cycle(3'b000, 32'h0, 32'h0, 32'h0);
    cycle(3'b110, 32'h0, 32'h31, 32'h32);
    pulse_reset("rst_wait");
    for (int i = 0; i < 6; i++) cycle(3'b111, 32'h50, 32'h54, 32'h58);
    idle(3);

    // Reset while in RESP.
    cycle(3'b100, 32'h0, 32'h0, 32'h60);
    cycle(3'b000, 32'h0, 32'h0, 32'h0);
    pulse_reset("rst_resp");
    idle(2);

    // Six fetches under full contention from a fresh reset.
    for (int i = 0; i < 18; i++) cycle(3'b111, 32'h70, 32'h74, 32'h78);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
